spmv_fp_mul_pipe: RTL and testbench

Parametrised, pipelined floating-point multiplier for the SpMV datapath. It is the successor to the fixed fp16 multiplier and is generic in exponent and mantissa width, with a default configuration of fp16. It adds a valid/ready handshake with backpressure, round-to-nearest-even, IEEE special-case handling, exception flags, and a row-end tag carried alongside each product. It sits between the CSR value/vector fetch stage and the row accumulator.

---
 rtl/spmv_fp_pkg.sv | 23 ++
 rtl/spmv_fp_round.sv | 64 ++++++
 rtl/spmv_fp_mul_pipe.sv | 173 +++++++++++++++++
 tb/tb_spmv_fp_mul_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_fp_pkg.sv
// Shared definitions for the SpMV floating-point datapath.
//   bias(exp_w)        : exponent bias 2^(exp_w-1)-1
//   qnan(exp_w, man_w) : canonical quiet NaN (sign 0, exponent all-ones,
//                        mantissa MSB set), right-aligned in 64 bits
//   FLAG_*             : bit positions inside the 3-bit exception flag vector
package spmv_fp_pkg;

  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/spmv_fp_round.sv
// Combinational normalise / round-to-nearest-even / pack for the multiplier.
//   prod    : raw (MAN_W+1)x(MAN_W+1) mantissa product, hidden bits included
//   exp_sum : biased exponent expA + expB - BIAS, signed
//   sign    : result sign
//   result  : packed result (signed inf on overflow, signed zero on underflow)
//   ovf/unf : range exception for this result
module spmv_fp_round
  import spmv_fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic [2*MAN_W+1:0]       prod,
  input  logic signed [EXP_W+1:0]  exp_sum,
  input  logic                     sign,
  output logic [W-1:0]             result,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] EMAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EZERO = '0;

  logic [PW-1:0]           norm;
  logic [MAN_W:0]          keep;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [MAN_W+1:0]        rounded;
  logic                    carry;
  logic [MAN_W-1:0]        frac;
  logic signed [EXP_W+1:0] exp_fin;

  always_comb begin
    // Product of two normal mantissas is in [1,4): either the top bit is set
    // (value >= 2, exponent +1) or the next bit is; shift so the leading one
    // always lands in the MSB.
    norm     = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
    keep     = norm[PW-1:MAN_W+1];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | keep[0]);
    rounded  = {1'b0, keep} + {{(MAN_W+1){1'b0}}, round_up};
    // Carry-out only happens when keep was all ones, so the rounded
    // mantissa is exactly 1.0 at the next exponent.
    carry    = rounded[MAN_W+1];
    frac     = carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    exp_fin  = exp_sum
             + $signed({{(EXP_W+1){1'b0}}, prod[PW-1]})
             + $signed({{(EXP_W+1){1'b0}}, carry});
    ovf      = (exp_fin >= EMAX);
    unf      = (exp_fin <= EZERO);
    if (ovf) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf) begin
      result = {sign, {(W-1){1'b0}}};
    end else begin
      result = {sign, exp_fin[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/spmv_fp_mul_pipe.sv
// Pipelined floating-point multiplier for the SpMV datapath.
//   i_clk, i_rstn        : clock, asynchronous active-low reset
//   i_valid / o_ready    : operand handshake (i_vector, i_value, i_last)
//   o_valid / i_ready    : result handshake (o_result, o_last, o_flags)
//   o_flags              : {invalid, overflow, underflow} of o_result
// Stages: S1 unpack/specials/exponent sum, S2 mantissa multiply,
// S3 normalise/round/pack into the output registers.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. o_ready = en = !o_valid || i_ready; the whole pipeline advances
// together on en, so a stall freezes every stage (bubbles included) and the
// output registers stay stable while o_valid && !i_ready. i_valid must not
// be a function of o_ready.
module spmv_fp_mul_pipe
  import spmv_fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_vector,
  input  logic [W-1:0] i_value,
  input  logic         i_last,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_result,
  output logic         o_last,
  output logic [2:0]   o_flags
);

  localparam int PW     = 2 * MAN_W + 2;
  localparam int BIAS_I = bias(EXP_W);
  localparam logic [EXP_W+1:0] BIAS_V = BIAS_I[EXP_W+1:0];
  localparam logic [63:0]      QNAN64 = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN   = QNAN64[W-1:0];

  logic en;
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // ---------------- S1 combinational: unpack and classify ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sgn;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             spec;
  logic [W-1:0]     spec_res;
  logic [2:0]       spec_flags;

  assign ea  = i_vector[W-2:MAN_W];
  assign eb  = i_value[W-2:MAN_W];
  assign fa  = i_vector[MAN_W-1:0];
  assign fb  = i_value[MAN_W-1:0];
  assign sgn = i_vector[W-1] ^ i_value[W-1];

  // Exponent 0 covers true zero and flushed subnormals alike.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);

  always_comb begin
    spec       = 1'b1;
    spec_res   = QNAN;
    spec_flags = 3'b000;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res             = QNAN;
      spec_flags[FLAG_INV] = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      spec = 1'b0;
    end
  end

  // ---------------- stage registers ----------------
  logic                    v1, last1, sign1, spec1;
  logic signed [EXP_W+1:0] exp1;
  logic [MAN_W:0]          man_a1, man_b1;
  logic [W-1:0]            spec_res1;
  logic [2:0]              spec_flags1;

  logic                    v2, last2, sign2, spec2;
  logic signed [EXP_W+1:0] exp2;
  logic [PW-1:0]           prod2;
  logic [W-1:0]            spec_res2;
  logic [2:0]              spec_flags2;

  logic [W-1:0]            rnd_res;
  logic                    rnd_ovf, rnd_unf;
  logic [2:0]              rnd_flags;

  spmv_fp_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .W     (W)
  ) u_round (
    .prod    (prod2),
    .exp_sum (exp2),
    .sign    (sign2),
    .result  (rnd_res),
    .ovf     (rnd_ovf),
    .unf     (rnd_unf)
  );

  always_comb begin
    rnd_flags           = 3'b000;
    rnd_flags[FLAG_OVF] = rnd_ovf;
    rnd_flags[FLAG_UNF] = rnd_unf;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      v1          <= 1'b0;
      last1       <= 1'b0;
      sign1       <= 1'b0;
      spec1       <= 1'b0;
      exp1        <= '0;
      man_a1      <= '0;
      man_b1      <= '0;
      spec_res1   <= '0;
      spec_flags1 <= '0;
      v2          <= 1'b0;
      last2       <= 1'b0;
      sign2       <= 1'b0;
      spec2       <= 1'b0;
      exp2        <= '0;
      prod2       <= '0;
      spec_res2   <= '0;
      spec_flags2 <= '0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_last      <= 1'b0;
      o_flags     <= '0;
    end else if (en) begin
      // S1
      v1          <= i_valid;
      last1       <= i_last;
      sign1       <= sgn;
      spec1       <= spec;
      exp1        <= $signed({2'b00, ea} + {2'b00, eb} - BIAS_V);
      man_a1      <= {1'b1, fa};
      man_b1      <= {1'b1, fb};
      spec_res1   <= spec_res;
      spec_flags1 <= spec_flags;
      // S2
      v2          <= v1;
      last2       <= last1;
      sign2       <= sign1;
      spec2       <= spec1;
      exp2        <= exp1;
      prod2       <= {{(MAN_W+1){1'b0}}, man_a1} * {{(MAN_W+1){1'b0}}, man_b1};
      spec_res2   <= spec_res1;
      spec_flags2 <= spec_flags1;
      // S3
      o_valid     <= v2;
      o_last      <= last2;
      o_result    <= spec2 ? spec_res2 : rnd_res;
      o_flags     <= spec2 ? spec_flags2 : rnd_flags;
    end
  end

endmodule

// File: tb/tb_spmv_fp_mul_pipe.sv
module tb_spmv_fp_mul_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 16;
  localparam int EW    = W + 4;  // {last, flags[2:0], result}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_valid, o_ready, i_last, o_valid, i_ready, o_last;
  logic [W-1:0] i_vector, i_value, o_result;
  logic [2:0]   o_flags;

  spmv_fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .i_clk    (clk),
    .i_rstn   (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_vector (i_vector),
    .i_value  (i_value),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_last   (o_last),
    .o_flags  (o_flags)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int out_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out;
  logic          rand_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (fp16, value-level arithmetic) ----------
  function automatic logic [EW-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                           input logic l);
    int ea, eb, fa, fb, p, k, e, sh, q, rem, half;
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    a_nan  = (ea == 31) && (fa != 0); b_nan  = (eb == 31) && (fb != 0);
    a_inf  = (ea == 31) && (fa == 0); b_inf  = (eb == 31) && (fb == 0);
    a_zero = (ea == 0);               b_zero = (eb == 0);
    if (a_nan || b_nan) return {l, 3'b000, 16'h7E00};
    if ((a_inf && b_zero) || (b_inf && a_zero)) return {l, 3'b100, 16'h7E00};
    if (a_inf || b_inf) return {l, 3'b000, s, 15'h7C00};
    if (a_zero || b_zero) return {l, 3'b000, s, 15'h0000};
    // value = p * 2^(ea+eb-30-20); p has its leading one at bit 20 or 21
    p  = (1024 + fa) * (1024 + fb);
    k  = (p >= 2097152) ? 21 : 20;
    e  = k + ea + eb - 50 + 15;
    sh = k - 10;
    q  = p >> sh;
    rem  = p - (q << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {l, 3'b010, s, 15'h7C00};
    if (e <= 0)  return {l, 3'b001, s, 15'h0000};
    return {l, 3'b000, s, e[4:0], q[9:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    logic [4:0]  e;
    r = 16'($urandom);
    if ($urandom_range(0, 7) != 0) begin
      e = 5'($urandom_range(6, 24));
      r[14:10] = e;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic l,
                      input logic [EW-1:0] e);
    int w;
    i_vector = a;
    i_value  = b;
    i_last   = l;
    i_valid  = 1'b1;
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) chk("accept_timeout", 0, 1);
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic meas_lat(input string tag);
    int cyc;
    cyc = 1;
    while (!o_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(tag, cyc, 3);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] cur, e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = {o_last, o_flags, o_result};
      if (prev_stall && o_valid) chk("hold", cur, prev_out);
      if (o_valid && !i_ready) chk("stall_ready", o_ready, 0);
      if (o_valid && i_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out", cur, e);
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = cur;
    end
  end

  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      if (rand_on) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0]   da[9];
  logic [15:0]   db[9];
  logic [18:0]   dexp[9];

  initial begin
    int base;
    logic [15:0] ra, rb;
    logic        rl;

    da[0] = 16'h4700; db[0] = 16'h4200; dexp[0] = {3'b000, 16'h4D40};
    da[1] = 16'h3C01; db[1] = 16'h3E00; dexp[1] = {3'b000, 16'h3E02};
    da[2] = 16'h3C01; db[2] = 16'h3C01; dexp[2] = {3'b000, 16'h3C02};
    da[3] = 16'h7C00; db[3] = 16'h0000; dexp[3] = {3'b100, 16'h7E00};
    da[4] = 16'hFC00; db[4] = 16'h4000; dexp[4] = {3'b000, 16'hFC00};
    da[5] = 16'h7E00; db[5] = 16'h3C00; dexp[5] = {3'b000, 16'h7E00};
    da[6] = 16'h7BFF; db[6] = 16'h4000; dexp[6] = {3'b010, 16'h7C00};
    da[7] = 16'h0400; db[7] = 16'h3800; dexp[7] = {3'b001, 16'h0000};
    da[8] = 16'h0200; db[8] = 16'h4000; dexp[8] = {3'b000, 16'h0000};

    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_vector = '0;
    i_value  = '0;
    i_last   = 1'b0;
    #3;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_out", {o_last, o_flags, o_result}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic product with latency
    send(16'h4700, 16'h4200, 1'b1, {1'b1, 3'b000, 16'h4D40});
    meas_lat("latency");
    drain();

    // directed table, back to back
    for (int i = 0; i < 9; i++) begin
      rl = i[0];
      send(da[i], db[i], rl, {rl, dexp[i]});
    end
    drain();

    // backpressure: 6 products, 4-cycle stall mid-stream
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = rand_op();
          rb = rand_op();
          rl = i[0];
          send(ra, rb, rl, model(ra, rb, rl));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", out_cnt - base, 6);

    // randomized stream with random downstream readiness
    rand_on = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ra = rand_op();
      rb = rand_op();
      rl = 1'($urandom_range(0, 1));
      send(ra, rb, rl, model(ra, rb, rl));
    end
    rand_on = 1'b0;
    @(posedge clk);
    #2 i_ready = 1'b1;
    drain();

    // reset with three products in flight (pipeline stalled, output loaded)
    i_ready = 1'b0;
    send(16'h7BFF, 16'h4000, 1'b1, {1'b1, 3'b010, 16'h7C00});
    send(16'h4700, 16'h4200, 1'b1, {1'b1, 3'b000, 16'h4D40});
    send(16'h3C01, 16'h3C01, 1'b1, {1'b1, 3'b000, 16'h3C02});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_out", {o_last, o_flags, o_result}, 0);
    chk("mid_rst_ready", o_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    i_ready = 1'b1;
    base    = out_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale", out_cnt - base, 0);
    send(16'h4700, 16'h4200, 1'b0, {1'b0, 3'b000, 16'h4D40});
    meas_lat("latency_after_rst");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
